// File: rtl/display_pkg.sv
// Shared constants and state encoding for the HUB75 framebuffer host-side loaders.
package display_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_FULL    = 8'h01;
    localparam logic [7:0] CMD_WINDOW  = 8'h02;

    localparam int FRAME_WORDS = 96 * 48 / 2;
    localparam int ADDR_W      = 12;

    // One framebuffer word carries the upper-half and lower-half pixel of a column pair.
    localparam int PIX_W       = 12;
    localparam int WORD_W      = 2 * PIX_W;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_CNT_H,
        ST_CNT_L,
        ST_D0,
        ST_D1,
        ST_D2
    } state_t;

endpackage

// File: rtl/frame_loader_timeout.sv
// Loadable inter-byte watchdog: reload on activity, count down while armed, pulse on expiry.
module frame_loader_timeout #(
    parameter int CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CW'(CYCLES);
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Fires during the last counted cycle so the owner can react on the CYCLES-th edge.
    assign o_expire = i_en && !i_load && !i_clear && (r_count == CW'(1));

endmodule

// File: rtl/frame_loader.sv
// Byte-stream command parser that writes 24-bit words into the display framebuffer port A.
module frame_loader
    import display_pkg::*;
#(
    parameter int         WIDTH          = 96,
    parameter int         HEIGHT         = 48,
    parameter logic [7:0] SYNC_BYTE      = display_pkg::SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 250000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic [ADDR_W-1:0] addr_a,
    output logic [WORD_W-1:0] data_in_a,
    output logic              wr_en,
    output logic              rd_en,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_err
);

    localparam int                L_FRAME_WORDS = WIDTH * HEIGHT / 2;
    localparam logic [ADDR_W:0]   L_FRAME_LIMIT = (ADDR_W + 1)'(L_FRAME_WORDS);

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic [ADDR_W-1:0]   r_cnt, w_cnt_next;
    logic [7:0]          r_b0, w_b0_next;
    logic [7:0]          r_b1, w_b1_next;
    logic [ADDR_W-1:0]   w_addr_a_next;
    logic [WORD_W-1:0]   w_data_next;
    logic                w_wr_en_next;
    logic                w_done_next;
    logic                w_err_next;
    logic [ADDR_W-1:0]   w_win_cnt;
    logic [ADDR_W:0]     w_win_end;
    logic                w_expire;

    assign w_win_cnt = {r_cnt[ADDR_W-1:8], i_byte};
    assign w_win_end = {1'b0, r_addr} + {1'b0, w_win_cnt};
    assign o_busy    = (r_state != ST_IDLE);
    assign rd_en     = 1'b0;

    frame_loader_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (i_byte_valid),
        .i_clear  (!o_busy),
        .i_en     (o_busy),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_b0         <= '0;
            r_b1         <= '0;
            addr_a       <= '0;
            data_in_a    <= '0;
            wr_en        <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_addr       <= w_addr_next;
            r_cnt        <= w_cnt_next;
            r_b0         <= w_b0_next;
            r_b1         <= w_b1_next;
            addr_a       <= w_addr_a_next;
            data_in_a    <= w_data_next;
            wr_en        <= w_wr_en_next;
            o_frame_done <= w_done_next;
            o_err        <= w_err_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_addr_next   = r_addr;
        w_cnt_next    = r_cnt;
        w_b0_next     = r_b0;
        w_b1_next     = r_b1;
        w_addr_a_next = addr_a;
        w_data_next   = data_in_a;
        w_wr_en_next  = 1'b0;
        w_done_next   = 1'b0;
        w_err_next    = 1'b0;

        if (i_byte_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_byte == SYNC_BYTE) w_state_next = ST_CMD;
                end
                ST_CMD: begin
                    if (i_byte == CMD_FULL) begin
                        w_addr_next  = '0;
                        w_cnt_next   = ADDR_W'(L_FRAME_WORDS);
                        w_state_next = ST_D0;
                    end else if (i_byte == CMD_WINDOW) begin
                        w_state_next = ST_ADDR_H;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                ST_ADDR_H: begin
                    w_addr_next  = {i_byte[3:0], r_addr[7:0]};
                    w_state_next = ST_ADDR_L;
                end
                ST_ADDR_L: begin
                    w_addr_next  = {r_addr[ADDR_W-1:8], i_byte};
                    w_state_next = ST_CNT_H;
                end
                ST_CNT_H: begin
                    w_cnt_next   = {i_byte[3:0], r_cnt[7:0]};
                    w_state_next = ST_CNT_L;
                end
                ST_CNT_L: begin
                    // 13-bit sum so a window ending exactly at the frame end is accepted.
                    if ((w_win_cnt == '0) || (w_win_end > L_FRAME_LIMIT)) begin
                        w_err_next   = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next   = w_win_cnt;
                        w_state_next = ST_D0;
                    end
                end
                ST_D0: begin
                    w_b0_next    = i_byte;
                    w_state_next = ST_D1;
                end
                ST_D1: begin
                    w_b1_next    = i_byte;
                    w_state_next = ST_D2;
                end
                ST_D2: begin
                    w_addr_a_next = r_addr;
                    w_data_next   = {r_b0, r_b1, i_byte};
                    w_wr_en_next  = 1'b1;
                    w_addr_next   = r_addr + 1'b1;
                    w_cnt_next    = r_cnt - 1'b1;
                    if (r_cnt == ADDR_W'(1)) begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_D0;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end else if (w_expire) begin
            w_err_next   = 1'b1;
            w_state_next = ST_IDLE;
        end
    end

endmodule
